eth_tx_frame_arbiter: RTL

ETH_TX_FRAME_ARBITER -- requirements
Module: eth_tx_frame_arbiter

---
 rtl/eth_tx_frame_arbiter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/eth_tx_frame_arbiter.sv
// Two-requester Ethernet TX frame arbiter: round-robin per-frame grant, byte
// pass-through to the MAC, truncation of oversize frames and inter-packet gap.
module eth_tx_frame_arbiter #(
    parameter int max_bytes_p  = 1514,
    parameter int ipg_cycles_p = 12
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic [7:0] req0_data_i,
    input  logic       req0_v_i,
    input  logic       req0_last_i,
    output logic       req0_ready_o,
    input  logic [7:0] req1_data_i,
    input  logic       req1_v_i,
    input  logic       req1_last_i,
    output logic       req1_ready_o,
    output logic [7:0] tx_data_o,
    output logic       tx_v_o,
    output logic       tx_last_o,
    input  logic       tx_ready_i,
    output logic [1:0] grant_o,
    output logic       trunc_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam logic [10:0] CNT_LAST = 11'(max_bytes_p - 1);
    localparam int GAP_W = (ipg_cycles_p > 2) ? $clog2(ipg_cycles_p) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((ipg_cycles_p > 0) ? (ipg_cycles_p - 1) : 0);

    state_t           r_state;
    logic [1:0]       r_grant;
    logic             r_rr;
    logic [10:0]      r_cnt;
    logic [GAP_W-1:0] r_gap_cnt;
    logic             r_trunc;

    state_t           w_state_nxt;
    logic [1:0]       w_grant_nxt;
    logic             w_rr_nxt;
    logic [10:0]      w_cnt_nxt;
    logic [GAP_W-1:0] w_gap_nxt;
    logic             w_trunc_nxt;

    logic [7:0]       w_sel_data;
    logic             w_sel_v;
    logic             w_sel_last;
    logic             w_at_max;
    logic             w_gap_done;
    logic [7:0]       w_tx_data;
    logic             w_tx_v;
    logic             w_tx_last;
    logic             w_rdy0;
    logic             w_rdy1;

    // The granted requester drives the byte path; grant is one-hot so bit 1 picks.
    assign w_sel_data = r_grant[1] ? req1_data_i : req0_data_i;
    assign w_sel_v    = r_grant[1] ? req1_v_i    : req0_v_i;
    assign w_sel_last = r_grant[1] ? req1_last_i : req0_last_i;
    assign w_at_max   = (r_cnt == CNT_LAST);
    assign w_gap_done = (ipg_cycles_p == 0) || (r_gap_cnt == GAP_LAST);

    // State and datapath registers; reset abandons any frame in flight.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state   <= ST_IDLE;
            r_grant   <= 2'b00;
            r_rr      <= 1'b0;
            r_cnt     <= 11'd0;
            r_gap_cnt <= '0;
            r_trunc   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_rr      <= w_rr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_gap_cnt <= w_gap_nxt;
            r_trunc   <= w_trunc_nxt;
        end
    end

    // Next-state, counter updates and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_rr_nxt    = r_rr;
        w_cnt_nxt   = r_cnt;
        w_gap_nxt   = r_gap_cnt;
        w_trunc_nxt = 1'b0;
        w_tx_data   = 8'd0;
        w_tx_v      = 1'b0;
        w_tx_last   = 1'b0;
        w_rdy0      = 1'b0;
        w_rdy1      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (req0_v_i && req1_v_i) begin
                    w_grant_nxt = r_rr ? 2'b10 : 2'b01;
                    w_cnt_nxt   = 11'd0;
                    w_state_nxt = ST_SEND;
                end else if (req0_v_i) begin
                    w_grant_nxt = 2'b01;
                    w_cnt_nxt   = 11'd0;
                    w_state_nxt = ST_SEND;
                end else if (req1_v_i) begin
                    w_grant_nxt = 2'b10;
                    w_cnt_nxt   = 11'd0;
                    w_state_nxt = ST_SEND;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_SEND: begin
                w_tx_data = w_sel_data;
                w_tx_v    = w_sel_v;
                w_tx_last = w_sel_v && (w_sel_last || w_at_max);
                w_rdy0    = r_grant[0] && tx_ready_i;
                w_rdy1    = r_grant[1] && tx_ready_i;
                if (w_sel_v && tx_ready_i) begin
                    w_cnt_nxt = r_cnt + 11'd1;
                    // At the size limit a frame without last is cut: the rest is drained.
                    if (w_at_max && !w_sel_last) begin
                        w_trunc_nxt = 1'b1;
                        w_state_nxt = ST_DRAIN;
                    end else if (w_sel_last) begin
                        w_gap_nxt   = '0;
                        w_state_nxt = ST_GAP;
                    end else begin
                        w_state_nxt = ST_SEND;
                    end
                end else begin
                    w_state_nxt = ST_SEND;
                end
            end

            ST_DRAIN: begin
                w_rdy0 = r_grant[0];
                w_rdy1 = r_grant[1];
                if (w_sel_v && w_sel_last) begin
                    w_gap_nxt   = '0;
                    w_state_nxt = ST_GAP;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end

            ST_GAP: begin
                if (w_gap_done) begin
                    w_rr_nxt    = r_grant[0];
                    w_grant_nxt = 2'b00;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gap_nxt   = r_gap_cnt + GAP_W'(1);
                    w_state_nxt = ST_GAP;
                end
            end

            default: begin
                w_grant_nxt = 2'b00;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign tx_data_o    = w_tx_data;
    assign tx_v_o       = w_tx_v;
    assign tx_last_o    = w_tx_last;
    assign req0_ready_o = w_rdy0;
    assign req1_ready_o = w_rdy1;
    assign grant_o      = r_grant;
    assign trunc_o      = r_trunc;

endmodule
